// File: rtl/ad9653_spi_cfg.sv
// AD9653 3-wire SPI configuration master: 24-bit MSB-first frames, one CSB per ADC,
// and an independent periodic SYNC generator. One command at a time; CMD_VALID outside IDLE is ignored.
`timescale 1ns/1ps

module ad9653_spi_cfg #(
  parameter int CLK_DIV     = 4,
  parameter int NUM_DEV     = 2,
  parameter int DEV_W       = 4,
  parameter int SYNC_PERIOD = 5000,
  parameter int SYNC_WIDTH  = 125
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CMD_VALID,
  output logic               CMD_READY,
  input  logic               CMD_RW,
  input  logic [DEV_W-1:0]   CMD_DEV,
  input  logic [12:0]        CMD_ADDR,
  input  logic [7:0]         CMD_WDATA,
  output logic               RSP_VALID,
  output logic [7:0]         RSP_RDATA,
  output logic               CMD_ERR,
  output logic               BUSY,
  output logic [NUM_DEV-1:0] AD_CSB,
  output logic               AD_SCLK,
  output logic               AD_SDIO_O,
  output logic               AD_SDIO_OE,
  input  logic               AD_SDIO_I,
  input  logic               SYNC_EN,
  output logic               AD_SYNC
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int SYNC_W = $clog2(SYNC_PERIOD);
  localparam logic [DIV_W-1:0]  PH_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [DEV_W:0]    NUM_DEV_X  = (DEV_W + 1)'(NUM_DEV);
  localparam logic [SYNC_W-1:0] SYNC_LAST  = SYNC_W'(SYNC_PERIOD - 1);
  localparam logic [SYNC_W-1:0] SYNC_HIGH  = SYNC_W'(SYNC_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t              state_q, state_d;
  logic [22:0]         sh_q, sh_d;
  logic [4:0]          bit_q, bit_d;
  logic [DIV_W-1:0]    ph_q, ph_d;
  logic                rw_q, rw_d;
  logic                ok_q, ok_d;
  logic [NUM_DEV-1:0]  csb_q, csb_d;
  logic                sclk_q, sclk_d;
  logic                sdo_q, sdo_d;
  logic                oe_q, oe_d;
  logic [7:0]          rd_q, rd_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic                err_q, err_d;
  logic [SYNC_W-1:0]   sync_cnt_q, sync_cnt_d;

  logic                dev_ok;
  logic [NUM_DEV-1:0]  dev_sel;
  logic [23:0]         frame;

  assign dev_ok = {1'b0, CMD_DEV} < NUM_DEV_X;
  assign frame  = {CMD_RW, 2'b00, CMD_ADDR, (CMD_RW ? 8'h00 : CMD_WDATA)};

  always_comb begin
    dev_sel = '1;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (CMD_DEV == DEV_W'(i)) dev_sel[i] = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    bit_d     = bit_q;
    ph_d      = ph_q;
    rw_d      = rw_q;
    ok_d      = ok_q;
    csb_d     = csb_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    oe_d      = oe_q;
    rd_d      = rd_q;
    rdata_d   = rdata_q;
    rsp_vld_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          state_d = SHIFT;
          rw_d    = CMD_RW;
          ok_d    = dev_ok;
          sh_d    = frame[22:0];
          sdo_d   = frame[23];
          bit_d   = '0;
          ph_d    = '0;
          sclk_d  = 1'b0;
          oe_d    = 1'b1;
          csb_d   = dev_ok ? dev_sel : '1;
        end
      end

      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
            // Read data is taken on the same CLK edge that raises SCLK.
            if (rw_q && (bit_q >= 5'd16)) rd_d = {rd_q[6:0], AD_SDIO_I};
          end else begin
            sclk_d = 1'b0;
            if (bit_q == 5'd23) begin
              state_d = HOLD;
              csb_d   = '1;
              oe_d    = 1'b0;
              sdo_d   = 1'b0;
            end else begin
              bit_d = bit_q + 5'd1;
              sdo_d = sh_q[22];
              sh_d  = {sh_q[21:0], 1'b0};
              // Turn the pad around for the 8 data bits of a read.
              oe_d  = !(rw_q && (bit_q >= 5'd15));
            end
          end
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (ph_q == PH_LAST) begin
          state_d = IDLE;
          ph_d    = '0;
          if (!ok_q) begin
            err_d = 1'b1;
          end else if (rw_q) begin
            rsp_vld_d = 1'b1;
            rdata_d   = rd_q;
          end
        end else begin
          ph_d = ph_q + DIV_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_cnt_d = '0;
    if (SYNC_EN && (sync_cnt_q != SYNC_LAST)) sync_cnt_d = sync_cnt_q + SYNC_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      bit_q      <= '0;
      ph_q       <= '0;
      rw_q       <= 1'b0;
      ok_q       <= 1'b0;
      csb_q      <= '1;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      oe_q       <= 1'b0;
      rd_q       <= '0;
      rdata_q    <= '0;
      rsp_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_q      <= bit_d;
      ph_q       <= ph_d;
      rw_q       <= rw_d;
      ok_q       <= ok_d;
      csb_q      <= csb_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      oe_q       <= oe_d;
      rd_q       <= rd_d;
      rdata_q    <= rdata_d;
      rsp_vld_q  <= rsp_vld_d;
      err_q      <= err_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign CMD_READY  = (state_q == IDLE);
  assign BUSY       = !CMD_READY;
  assign AD_CSB     = csb_q;
  assign AD_SCLK    = sclk_q;
  assign AD_SDIO_O  = sdo_q;
  assign AD_SDIO_OE = oe_q;
  assign RSP_VALID  = rsp_vld_q;
  assign RSP_RDATA  = rdata_q;
  assign CMD_ERR    = err_q;
  // Gated by SYNC_EN and RST directly so both take effect without waiting for a clock.
  assign AD_SYNC    = SYNC_EN & ~RST & (sync_cnt_q < SYNC_HIGH);

endmodule
